// File: rtl/snn_step_scheduler_if.sv
// Injection request channel between the host/stimulus logic and
// snn_step_scheduler. The host (master) offers one neuron index per cycle;
// the scheduler (slave) accepts it while its injection window is open.
//   inj_valid  : request valid
//   inj_ready  : request accepted (window open)
//   inj_neuron : neuron index to force
//   inj_last   : final injection for the current time step
interface snn_step_scheduler_if #(
  parameter int unsigned N = 8
);
  localparam int unsigned NW = (N > 1) ? $clog2(N) : 1;

  logic          inj_valid;
  logic          inj_ready;
  logic [NW-1:0] inj_neuron;
  logic          inj_last;

  modport master (
    output inj_valid,
    output inj_neuron,
    output inj_last,
    input  inj_ready
  );

  modport slave (
    input  inj_valid,
    input  inj_neuron,
    input  inj_last,
    output inj_ready
  );
endinterface

// File: rtl/snn_step_scheduler.sv
// Time-step sequencer for a single neuron_block.
// Each step: open an injection window (requests serialised onto the block's
// force port one per cycle), pulse time_step, wait for the neurons to settle,
// then capture spike_out into a T-deep history that feeds spike_in.
// Ports:
//   aclk, aresetn             : clock, synchronous active-low reset
//   run                       : level, keep stepping while high
//   clear                     : pulse, zero history and step_count (IDLE only)
//   inj                       : injection request channel (slave side)
//   force_spike_en/_select    : registered force pulse and neuron index
//   time_step                 : one-cycle step pulse to neuron_block
//   spike_out                 : spike vector from neuron_block
//   spike_in                  : history, [0] newest, [T-1] oldest
//   step_count                : completed steps (wraps)
//   step_done                 : one-cycle pulse per completed step
//   busy                      : high whenever not IDLE
module snn_step_scheduler #(
  parameter  int unsigned N         = 8,
  parameter  int unsigned T         = 4,
  parameter  int unsigned SETTLE    = 3,
  parameter  int unsigned INJ_MAX   = 16,
  parameter  int unsigned NUM_STEPS = 0,
  localparam int unsigned NW        = (N > 1) ? $clog2(N) : 1
) (
  input  logic                  aclk,
  input  logic                  aresetn,
  input  logic                  run,
  input  logic                  clear,
  snn_step_scheduler_if.slave   inj,
  output logic                  force_spike_en,
  output logic [NW-1:0]         force_spike_neuron_select,
  output logic                  time_step,
  input  logic [N-1:0]          spike_out,
  output logic [T-1:0][N-1:0]   spike_in,
  output logic [31:0]           step_count,
  output logic                  step_done,
  output logic                  busy
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_INJECT,
    S_STEP,
    S_SETTLE,
    S_CAPTURE
  } state_e;

  state_e               state_q, state_d;
  logic [7:0]           cnt_q, cnt_d;
  logic                 force_en_q, force_en_d;
  logic [NW-1:0]        force_sel_q, force_sel_d;
  logic                 time_step_q, time_step_d;
  logic                 step_done_q, step_done_d;
  logic                 busy_q, busy_d;
  logic [T-1:0][N-1:0]  hist_q, hist_d;
  logic [31:0]          step_cnt_q, step_cnt_d;
  logic                 hold_q, hold_d;
  logic                 hs;

  assign inj.inj_ready = (state_q == S_INJECT);

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q + 8'd1;
    force_en_d  = 1'b0;
    force_sel_d = '0;
    hist_d      = hist_q;
    step_cnt_d  = step_cnt_q;
    // Set when the step limit stops a run; released only once run is seen low.
    hold_d      = hold_q & run;
    hs          = inj.inj_valid && (state_q == S_INJECT);

    unique case (state_q)
      S_IDLE: begin
        cnt_d = '0;
        if (clear) begin
          hist_d     = '0;
          step_cnt_d = '0;
        end else if (run && !hold_q) begin
          state_d = S_INJECT;
        end
      end
      S_INJECT: begin
        if (hs) begin
          force_en_d  = 1'b1;
          force_sel_d = inj.inj_neuron;
        end
        if ((hs && inj.inj_last) || (cnt_q == 8'(INJ_MAX - 1))) begin
          state_d = S_STEP;
          cnt_d   = '0;
        end
      end
      S_STEP: begin
        state_d = S_SETTLE;
        cnt_d   = '0;
      end
      S_SETTLE: begin
        if (cnt_q == 8'(SETTLE - 1)) begin
          state_d = S_CAPTURE;
          cnt_d   = '0;
        end
      end
      S_CAPTURE: begin
        cnt_d     = '0;
        hist_d[0] = spike_out;
        for (int unsigned k = 1; k < T; k++) begin
          hist_d[k] = hist_q[k-1];
        end
        step_cnt_d = step_cnt_q + 32'd1;
        if (!run) begin
          state_d = S_IDLE;
        end else if ((NUM_STEPS != 0) && (step_cnt_d == 32'(NUM_STEPS))) begin
          state_d = S_IDLE;
          hold_d  = 1'b1;
        end else begin
          state_d = S_INJECT;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // time_step and step_done are registered decodes of the current state,
    // so they appear the cycle after STEP / CAPTURE respectively.
    time_step_d = (state_q == S_STEP);
    step_done_d = (state_q == S_CAPTURE);
    busy_d      = (state_d != S_IDLE);
  end

  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      force_en_q  <= 1'b0;
      force_sel_q <= '0;
      time_step_q <= 1'b0;
      step_done_q <= 1'b0;
      busy_q      <= 1'b0;
      hist_q      <= '0;
      step_cnt_q  <= '0;
      hold_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      force_en_q  <= force_en_d;
      force_sel_q <= force_sel_d;
      time_step_q <= time_step_d;
      step_done_q <= step_done_d;
      busy_q      <= busy_d;
      hist_q      <= hist_d;
      step_cnt_q  <= step_cnt_d;
      hold_q      <= hold_d;
    end
  end

  assign force_spike_en            = force_en_q;
  assign force_spike_neuron_select = force_sel_q;
  assign time_step                 = time_step_q;
  assign step_done                 = step_done_q;
  assign busy                      = busy_q;
  assign spike_in                  = hist_q;
  assign step_count                = step_cnt_q;

endmodule

// File: tb/tb_snn_step_scheduler.sv
module tb_snn_step_scheduler;
  localparam int unsigned N       = 8;
  localparam int unsigned T       = 4;
  localparam int unsigned SETTLE  = 3;
  localparam int unsigned INJ_MAX = 16;

  logic aclk = 1'b0;
  always #5 aclk = ~aclk;

  logic              aresetn, run, clear;
  logic [N-1:0]      spike_out;
  logic              force_spike_en, time_step, step_done, busy;
  logic [2:0]        force_spike_neuron_select;
  logic [T-1:0][N-1:0] spike_in;
  logic [31:0]       step_count;

  logic              run1;
  logic [N-1:0]      spike_out1;
  logic              force_en1, time_step1, step_done1, busy1;
  logic [2:0]        force_sel1;
  logic [T-1:0][N-1:0] spike_in1;
  logic [31:0]       step_count1;

  snn_step_scheduler_if #(.N(N)) inj_if ();
  snn_step_scheduler_if #(.N(N)) inj_if1 ();

  snn_step_scheduler #(.N(N), .T(T), .SETTLE(SETTLE), .INJ_MAX(INJ_MAX), .NUM_STEPS(0)) dut (
    .aclk(aclk), .aresetn(aresetn), .run(run), .clear(clear), .inj(inj_if),
    .force_spike_en(force_spike_en), .force_spike_neuron_select(force_spike_neuron_select),
    .time_step(time_step), .spike_out(spike_out), .spike_in(spike_in),
    .step_count(step_count), .step_done(step_done), .busy(busy)
  );

  snn_step_scheduler #(.N(N), .T(T), .SETTLE(SETTLE), .INJ_MAX(2), .NUM_STEPS(3)) dut_lim (
    .aclk(aclk), .aresetn(aresetn), .run(run1), .clear(1'b0), .inj(inj_if1),
    .force_spike_en(force_en1), .force_spike_neuron_select(force_sel1),
    .time_step(time_step1), .spike_out(spike_out1), .spike_in(spike_in1),
    .step_count(step_count1), .step_done(step_done1), .busy(busy1)
  );

  int checks = 0;
  int errors = 0;

  // Reference state: history as an array shifted per completed step.
  logic [T-1:0][N-1:0] m_hist;
  logic [31:0]         m_cnt;
  logic [2:0]          req_nrn [4];

  typedef struct {
    bit          clr;
    int          n;
    bit          last;
    logic [11:0] nrn;
    logic [7:0]  spk;
    bit          keep;
    int          drop;
    bit          late;
    logic [31:0] exp_cnt;
    logic [31:0] exp_hist;
  } vec_t;
  vec_t tbl [6];

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [71:0] snap();
    return {busy, inj_if.inj_ready, time_step, step_done, force_spike_en,
            force_spike_neuron_select, spike_in, step_count};
  endfunction

  task automatic tick();
    @(posedge aclk);
    @(negedge aclk);
  endtask

  task automatic start_from_idle(input bit do_clear);
    if (do_clear) begin
      clear = 1'b1;
      run   = 1'b1;   // clear must win over run
      tick();
      m_hist = '0;
      m_cnt  = '0;
      check("clear_idle", snap(), 72'h0);
      clear = 1'b0;
    end
    run = 1'b1;
    tick();
    check("start", snap(), {1'b1, 1'b1, 6'b0, m_hist, m_cnt});
  endtask

  // One complete step from INJECT cycle 0. Expected waveform derived from the
  // step timeline: window length L, then STEP, SETTLE cycles, CAPTURE.
  task automatic run_step(input int n, input bit use_last, input logic [7:0] spk,
                          input bit keep, input int drop_c, input bit late,
                          input bit mid_clr);
    int L, total;
    logic eb, er, et, ed, ef;
    logic [2:0] es;
    L     = use_last ? n : INJ_MAX;
    total = L + SETTLE + 2;
    for (int c = 1; c <= total; c++) begin
      inj_if.inj_valid  = (c - 1 < n) || (late && (c - 1 >= L));
      inj_if.inj_neuron = 3'($urandom);
      if (c - 1 < n) inj_if.inj_neuron = req_nrn[c-1];
      inj_if.inj_last   = use_last && (c - 1 == n - 1);
      spike_out         = (c == total) ? spk : 8'($urandom);
      run               = (c <= drop_c) ? 1'b1 : keep;
      clear             = mid_clr ? 1'($urandom) : 1'b0;
      tick();
      if (c == total) begin
        m_hist = {m_hist[T-2:0], spk};
        m_cnt  = m_cnt + 32'd1;
      end
      eb = (c < total) ? 1'b1 : keep;
      er = (c < L) || ((c == total) && keep);
      et = (c == L + 1);
      ed = (c == total);
      ef = (c <= n);
      es = 3'd0;
      if (c <= n) es = req_nrn[c-1];
      check("step_cycle", snap(), {eb, er, et, ed, ef, es, m_hist, m_cnt});
    end
    inj_if.inj_valid = 1'b0;
    inj_if.inj_last  = 1'b0;
    clear            = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not complete");
    errors++;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $fatal(1);
  end

  initial begin
    bit idle;
    int pulses;

    aresetn = 1'b0; run = 1'b0; clear = 1'b0; spike_out = '0;
    inj_if.inj_valid = 1'b0; inj_if.inj_neuron = '0; inj_if.inj_last = 1'b0;
    run1 = 1'b0; spike_out1 = '0;
    inj_if1.inj_valid = 1'b0; inj_if1.inj_neuron = '0; inj_if1.inj_last = 1'b0;
    m_hist = '0; m_cnt = '0;

    // Reset and idle stability, with an injection request that must be ignored.
    tick();
    tick();
    check("reset", snap(), 72'h0);
    check("reset_lim", {busy1, step_count1}, 33'h0);
    aresetn = 1'b1;
    inj_if.inj_valid = 1'b1; inj_if.inj_neuron = 3'd4; inj_if.inj_last = 1'b1;
    for (int i = 0; i < 10; i++) begin
      spike_out = 8'($urandom);
      tick();
      check("idle", snap(), 72'h0);
    end
    inj_if.inj_valid = 1'b0; inj_if.inj_last = 1'b0;

    tbl[0] = '{0, 0, 0, 12'h000, 8'hA5, 0, 0, 1, 32'd1, 32'h000000A5};
    tbl[1] = '{1, 3, 1, {3'd0, 3'd7, 3'd5, 3'd2}, 8'h01, 1, 0, 0, 32'd1, 32'h00000001};
    tbl[2] = '{0, 1, 1, {3'd0, 3'd0, 3'd0, 3'd3}, 8'h02, 1, 0, 0, 32'd2, 32'h00000102};
    tbl[3] = '{0, 2, 0, {3'd0, 3'd0, 3'd6, 3'd1}, 8'h04, 1, 0, 0, 32'd3, 32'h00010204};
    tbl[4] = '{0, 4, 1, {3'd4, 3'd0, 3'd7, 3'd2}, 8'h08, 1, 0, 0, 32'd4, 32'h01020408};
    tbl[5] = '{0, 1, 1, {3'd0, 3'd0, 3'd0, 3'd5}, 8'h10, 0, 3, 0, 32'd5, 32'h02040810};

    idle = 1'b1;
    for (int i = 0; i < 6; i++) begin
      if (idle) start_from_idle(tbl[i].clr);
      for (int j = 0; j < 4; j++) req_nrn[j] = tbl[i].nrn[3*j +: 3];
      run_step(tbl[i].n, tbl[i].last, tbl[i].spk, tbl[i].keep, tbl[i].drop, tbl[i].late, 1'b0);
      check("tbl_count", step_count, tbl[i].exp_cnt);
      check("tbl_hist", spike_in, tbl[i].exp_hist);
      idle = !tbl[i].keep;
    end

    // Randomised steps, with clear toggling during steps (must be ignored).
    for (int i = 0; i < 20; i++) begin
      int n, L, drop;
      bit last, keep, late;
      n    = $urandom_range(0, 4);
      last = (n > 0) && ($urandom_range(0, 1) == 1);
      keep = ($urandom_range(0, 3) != 0);
      late = !keep && !last && ($urandom_range(0, 1) == 1);
      L    = last ? n : INJ_MAX;
      drop = $urandom_range(0, L + SETTLE + 1);
      for (int j = 0; j < 4; j++) req_nrn[j] = 3'($urandom);
      if (idle) start_from_idle($urandom_range(0, 3) == 0);
      run_step(n, last, 8'($urandom), keep, drop, late, 1'b1);
      idle = !keep;
    end
    if (!idle) begin
      run_step(0, 0, 8'h3C, 0, 0, 0, 0);
    end

    // Reset during SETTLE abandons the step.
    start_from_idle(1'b0);
    inj_if.inj_valid = 1'b1; inj_if.inj_neuron = 3'd6; inj_if.inj_last = 1'b1;
    tick();
    check("mid_inj", snap(), {1'b1, 1'b0, 3'b001, 3'd6, m_hist, m_cnt});
    inj_if.inj_valid = 1'b0; inj_if.inj_last = 1'b0;
    tick();
    check("mid_ts", snap(), {1'b1, 1'b0, 1'b1, 5'b0, m_hist, m_cnt});
    tick();
    aresetn = 1'b0; run = 1'b0; spike_out = 8'hFF;
    tick();
    m_hist = '0; m_cnt = '0;
    check("mid_reset", snap(), 72'h0);
    aresetn = 1'b1;
    for (int i = 0; i < 6; i++) begin
      tick();
      check("post_reset", snap(), 72'h0);
    end

    // Step limit of 3 with run held high, then restart after run drops.
    run1 = 1'b1;
    pulses = 0;
    for (int i = 0; i < 60; i++) begin
      spike_out1 = 8'($urandom);
      tick();
      if (step_done1) pulses++;
    end
    check("lim_pulses", pulses, 3);
    check("lim_idle", {busy1, step_count1}, {1'b0, 32'd3});
    run1 = 1'b0;
    tick();
    check("lim_low", busy1, 1'b0);
    run1 = 1'b1;
    tick();
    check("lim_restart", {busy1, inj_if1.inj_ready}, 2'b11);
    run1 = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
